// File: rtl/riscv_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_mem_pkg
// Description : Shared types and constants for the riscv_mem_responder slice.
//               State encoding, MMIO word offsets and the RAM address check
//               used for both the fetch and the load/store ports.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } mem_state_t;

    localparam logic [31:0] MMIO_CYCLE  = 32'd0;
    localparam logic [31:0] MMIO_HALT   = 32'd4;
    localparam logic [31:0] MMIO_STATUS = 32'd8;

    // True when a byte address is word aligned and falls inside the RAM.
    // The word index is compared rather than the byte address so that
    // 4*depth_words can never overflow.
    function automatic logic addr_in_ram(input logic [31:0] addr,
                                         input int unsigned depth_words);
        return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < depth_words);
    endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : riscv_mem_responder_if
// Description : Bus bundle between the core/boot harness (master) and the
//               memory responder (slave).
//               Fetch   : instr_addr -> instr_data
//               Data    : data_addr, data_wdata, data_we -> data_rdata
//               Loader  : load_valid, load_data, load_last -> load_ready
//               Control : core_reset, fault (from responder)
// Revision    : 1.0 - initial release
// ============================================================================
interface riscv_mem_responder_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] instr_addr;
    logic [DATA_WIDTH-1:0] instr_data;
    logic [DATA_WIDTH-1:0] data_addr;
    logic [DATA_WIDTH-1:0] data_wdata;
    logic                  data_we;
    logic [DATA_WIDTH-1:0] data_rdata;
    logic                  load_valid;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_last;
    logic                  load_ready;
    logic                  core_reset;
    logic                  fault;

    modport master (
        output instr_addr, data_addr, data_wdata, data_we,
               load_valid, load_data, load_last,
        input  instr_data, data_rdata, load_ready, core_reset, fault
    );

    modport slave (
        input  instr_addr, data_addr, data_wdata, data_we,
               load_valid, load_data, load_last,
        output instr_data, data_rdata, load_ready, core_reset, fault
    );
endinterface
`default_nettype wire

// File: rtl/riscv_mem_responder_ram.sv
`default_nettype none
// ============================================================================
// Module      : mem_word_ram
// Description : Word RAM with one synchronous write port and two
//               asynchronous read ports (fetch and data). Contents are not
//               reset. A read of the word being written in the same cycle
//               returns the old contents.
// Ports       : clk, we, waddr, wdata          - write port
//               raddr_a/rdata_a, raddr_b/rdata_b - read ports
// Revision    : 1.0 - initial release
// ============================================================================
module mem_word_ram #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  wire logic                  clk,
    input  wire logic                  we,
    input  wire logic [IDX_W-1:0]      waddr,
    input  wire logic [DATA_WIDTH-1:0] wdata,
    input  wire logic [IDX_W-1:0]      raddr_a,
    output logic      [DATA_WIDTH-1:0] rdata_a,
    input  wire logic [IDX_W-1:0]      raddr_b,
    output logic      [DATA_WIDTH-1:0] rdata_b
);
    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];
endmodule
`default_nettype wire

// File: rtl/riscv_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : riscv_mem_responder
// Description : Memory-side responder for the pipelined core. Streams a
//               program image into RAM while holding the core in reset, then
//               serves fetches, loads and stores, plus a 3-word MMIO window
//               (cycle counter, halt, fault status).
// Ports       : clk   - clock
//               reset - asynchronous, active-high
//               bus   - riscv_mem_responder_if.slave (fetch, data, loader,
//                       core_reset, fault)
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_mem_responder
    import riscv_mem_pkg::*;
#(
    parameter int              DATA_WIDTH  = 32,
    parameter int              DEPTH_WORDS = 1024,
    parameter logic [31:0]     MMIO_BASE   = 32'hFFFF_0000
) (
    input  wire logic               clk,
    input  wire logic               reset,
    riscv_mem_responder_if.slave    bus
);
    localparam int               IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

    mem_state_t            state, next_state;
    logic [IDX_W-1:0]      load_ptr;
    logic [DATA_WIDTH-1:0] cycle_cnt;
    logic                  fault_q;
    logic                  core_reset_q;
    logic                  load_ready_q;

    logic                  run;
    logic                  accept;
    logic                  instr_ok;
    logic                  data_ram_ok;
    logic                  is_cycle, is_halt, is_status;
    logic                  new_fault;
    logic                  halt_req;
    logic                  fault_clr;
    logic                  ram_we;
    logic [IDX_W-1:0]      ram_waddr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata_a, ram_rdata_b;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign run         = (state == RUN);
    assign accept      = (state == LOAD) && bus.load_valid && load_ready_q;
    assign instr_ok    = addr_in_ram(bus.instr_addr, DEPTH_WORDS);
    assign data_ram_ok = addr_in_ram(bus.data_addr, DEPTH_WORDS);
    assign is_cycle    = (bus.data_addr == MMIO_BASE + MMIO_CYCLE);
    assign is_halt     = (bus.data_addr == MMIO_BASE + MMIO_HALT);
    assign is_status   = (bus.data_addr == MMIO_BASE + MMIO_STATUS);

    // Every RUN cycle is an access on both ports, so any bad address counts.
    assign new_fault = run && (!instr_ok ||
                               !(data_ram_ok || is_cycle || is_halt || is_status));
    assign halt_req  = run && bus.data_we && is_halt   && bus.data_wdata[0];
    assign fault_clr = run && bus.data_we && is_status && bus.data_wdata[0];

    // Single write port: loader owns it in LOAD, core stores in RUN.
    assign ram_we    = accept || (run && bus.data_we && data_ram_ok);
    assign ram_waddr = run ? bus.data_addr[IDX_W+1:2] : load_ptr;
    assign ram_wdata = run ? bus.data_wdata : bus.load_data;

    mem_word_ram #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we),
        .waddr   (ram_waddr),
        .wdata   (ram_wdata),
        .raddr_a (bus.instr_addr[IDX_W+1:2]),
        .rdata_a (ram_rdata_a),
        .raddr_b (bus.data_addr[IDX_W+1:2]),
        .rdata_b (ram_rdata_b)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state     = state;
        bus.instr_data = '0;
        bus.data_rdata = '0;
        case (state)
            LOAD: begin
                if (accept && (bus.load_last || load_ptr == LAST_IDX)) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (halt_req) begin
                    next_state = HALT;
                end
                if (instr_ok) begin
                    bus.instr_data = ram_rdata_a;
                end
                if (data_ram_ok) begin
                    bus.data_rdata = ram_rdata_b;
                end else if (is_cycle) begin
                    bus.data_rdata = cycle_cnt;
                end else if (is_status) begin
                    bus.data_rdata = {{(DATA_WIDTH-1){1'b0}}, fault_q};
                end
            end
            default: begin
                next_state = HALT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_ptr     <= '0;
            cycle_cnt    <= '0;
            fault_q      <= 1'b0;
            core_reset_q <= 1'b1;
            load_ready_q <= 1'b1;
        end else begin
            // Pointer saturates at the last index rather than wrapping.
            if (accept && load_ptr != LAST_IDX) begin
                load_ptr <= load_ptr + IDX_W'(1);
            end
            if (run) begin
                cycle_cnt <= cycle_cnt + DATA_WIDTH'(1);
            end
            // A fresh fault beats a clear arriving in the same cycle.
            if (new_fault) begin
                fault_q <= 1'b1;
            end else if (fault_clr) begin
                fault_q <= 1'b0;
            end
            core_reset_q <= (next_state != RUN);
            load_ready_q <= (next_state == LOAD);
        end
    end

    assign bus.core_reset = core_reset_q;
    assign bus.load_ready = load_ready_q;
    assign bus.fault      = fault_q;
endmodule
`default_nettype wire

// File: doc/riscv_mem_responder.md
Name: riscv_mem_responder

Overview:
- Memory-side responder for the pipelined core's instruction and data memory ports.
- Holds the core in reset while a program image streams in over a valid/ready loader port, then serves instruction fetches and data loads/stores from a shared word RAM.
- Decodes a small MMIO window: a cycle counter, a halt register and a fault status register.
- Sits at top level between the core and the test/boot harness.

Parameters:
DATA_WIDTH, 32, width of address and data buses.
DEPTH_WORDS, 1024, number of 32-bit RAM words; power of two.
MMIO_BASE, 32'hFFFF_0000, byte base address of the MMIO window (3 words).

Ports:
clk  input  1  clock
reset  input  1  reset, asynchronous, active-high
instr_addr  input  DATA_WIDTH  byte address of the core fetch
instr_data  output  DATA_WIDTH  fetched instruction word
data_addr  input  DATA_WIDTH  byte address of the core load/store
data_wdata  input  DATA_WIDTH  store data
data_we  input  1  store strobe
data_rdata  output  DATA_WIDTH  load data
load_valid  input  1  loader word valid
load_data  input  DATA_WIDTH  loader word
load_last  input  1  marks the final loader word
load_ready  output  1  loader word accepted when high with load_valid
core_reset  output  1  active-high reset to the core
fault  output  1  sticky access fault

Behaviour:
- Reset values: state=LOAD, load_ptr=0, cycle_cnt=0, fault=0, core_reset=1. RAM contents are not cleared.
- State LOAD:
  - load_ready=1; instr_data=0; data_rdata=0; core writes ignored.
  - On load_valid&&load_ready: mem[load_ptr]<=load_data, then load_ptr++.
  - If the accepted word has load_last=1, or load_ptr==DEPTH_WORDS-1, go to RUN on the next edge. load_ptr never wraps.
- State RUN:
  - core_reset=0 (registered; low from the first RUN cycle); load_ready=0; cycle_cnt increments every cycle and wraps at 2^32.
  - instr_data is a combinational read of mem[instr_addr[log2(DEPTH)+1:2]].
    - If instr_addr[1:0]!=0 or instr_addr >= 4*DEPTH_WORDS: instr_data=0 and fault<=1.
  - data_rdata is a combinational read with the same word-index rule. MMIO decode:
    - MMIO_BASE+0 reads cycle_cnt; writes ignored.
    - MMIO_BASE+4 reads 0; a write with data_wdata[0]=1 enters HALT on the next edge.
    - MMIO_BASE+8 reads {31'b0, fault}; a write with data_wdata[0]=1 clears fault. A new fault in the same cycle wins over the clear.
  - Stores occur on the clock edge when data_we=1 and the address is aligned and inside the RAM.
  - A read of the same word being stored in the same cycle returns the old data.
  - A misaligned or unmapped data access (read or write) returns 0, drops the write and sets fault.
- State HALT:
  - core_reset=1; load_ready=0; cycle_cnt frozen; outputs read 0.
  - HALT is terminal until reset.
- Reset mid-load or mid-run: returns to LOAD with load_ptr=0. Previously loaded words persist until overwritten.
- All outputs other than instr_data and data_rdata are registered.

Decomposition:
- Package riscv_mem_pkg:
  - state enum mem_state_t {LOAD, RUN, HALT}.
  - MMIO offset constants MMIO_CYCLE=0, MMIO_HALT=4, MMIO_STATUS=8.
  - Alignment/range helper function.
- Sub-module mem_word_ram: one synchronous write port and two asynchronous read ports.
  - The write port is muxed between the loader and core stores by state.

Test Plan:
- Load 3 words (0x00500093, 0x00A00113, 0x002081B3) with load_last on the third:
  - load_ready drops and core_reset=0 on the cycle after the third accept.
  - instr_addr=4 returns 0x00A00113.
- Hold load_valid high for DEPTH_WORDS words without load_last:
  - The last word is written at index DEPTH_WORDS-1 and the block enters RUN.
  - No write hits index 0 again.
- In RUN, store 0xDEADBEEF to addr 0x40 with data_we=1, then read 0x40:
  - In the same cycle, data_rdata shows the old value.
  - The next cycle returns 0xDEADBEEF.
- Read MMIO_BASE+0 at N and N+5 cycles into RUN -> values differ by 5. Write 1 to MMIO_BASE+4 -> HALT, core_reset=1, counter frozen.
- Data read at addr 0x42 (misaligned), then at 4*DEPTH_WORDS:
  - Both return 0 and fault=1; the write is dropped.
  - Writing 1 to MMIO_BASE+8 clears fault; the status read then returns 0.
- Assert reset after 2 of 4 loader words:
  - State returns to LOAD, load_ptr=0, core_reset=1.
  - Reloading overwrites from index 0.
